// File: rtl/packet_rr_merge_n_to_1.sv
// Packet-aware round-robin merger: NUM_IN AXI-stream lanes into one output stream,
// one whole packet at a time, with the source lane index written into the ctl field.
module packet_rr_merge_n_to_1 #(
  parameter int DAT_BYTS    = 8,
  parameter int CTL_BITS    = 8,
  parameter int NUM_IN      = 8,
  parameter int OVR_WRT_BIT = 0,
  localparam int MOD_BITS   = (DAT_BYTS > 1) ? $clog2(DAT_BYTS) : 1,
  localparam int IDX_W      = $clog2(NUM_IN),
  localparam int DAT_W      = DAT_BYTS * 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NUM_IN-1:0]          i_n_axi_val,
  input  logic [NUM_IN-1:0]          i_n_axi_sop,
  input  logic [NUM_IN-1:0]          i_n_axi_eop,
  input  logic [NUM_IN-1:0]          i_n_axi_err,
  input  logic [NUM_IN*DAT_W-1:0]    i_n_axi_dat,
  input  logic [NUM_IN*CTL_BITS-1:0] i_n_axi_ctl,
  input  logic [NUM_IN*MOD_BITS-1:0] i_n_axi_mod,
  output logic [NUM_IN-1:0]          i_n_axi_rdy,
  output logic                       o_axi_val,
  output logic                       o_axi_sop,
  output logic                       o_axi_eop,
  output logic                       o_axi_err,
  output logic [DAT_W-1:0]           o_axi_dat,
  output logic [CTL_BITS-1:0]        o_axi_ctl,
  output logic [MOD_BITS-1:0]        o_axi_mod,
  input  logic                       o_axi_rdy
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;

  logic [IDX_W-1:0]   lane_s;
  logic [IDX_W-1:0]   win_s;
  logic               hit_s;
  logic               any_val_s;
  logic [IDX_W-1:0]   cur_s;
  logic               active_s;
  logic               out_free_s;
  logic               accept_s;
  logic [NUM_IN-1:0]  rdy_s;

  logic               sel_val_s;
  logic               sel_sop_s;
  logic               sel_eop_s;
  logic               sel_err_s;
  logic [DAT_W-1:0]   sel_dat_s;
  logic [CTL_BITS-1:0] sel_ctl_s;
  logic [CTL_BITS-1:0] ctl_ovr_s;
  logic [MOD_BITS-1:0] sel_mod_s;

  logic               o_val_q;
  logic               o_sop_q;
  logic               o_eop_q;
  logic               o_err_q;
  logic [DAT_W-1:0]   o_dat_q;
  logic [CTL_BITS-1:0] o_ctl_q;
  logic [MOD_BITS-1:0] o_mod_q;

  // Round-robin search: first valid lane starting just after the last grant.
  always_comb begin
    lane_s    = '0;
    hit_s     = 1'b0;
    win_s     = '0;
    any_val_s = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      lane_s    = IDX_W'((int'(last_grant_q) + 1 + i) % NUM_IN);
      hit_s     = !any_val_s && i_n_axi_val[lane_s];
      win_s     = hit_s ? lane_s : win_s;
      any_val_s = any_val_s | hit_s;
    end
  end

  // Handshake qualification: the lane being served may push a beat when the output slot frees.
  always_comb begin
    cur_s      = (state_q == ST_LOCKED) ? grant_q : win_s;
    active_s   = (state_q == ST_LOCKED) || any_val_s;
    out_free_s = !o_val_q || o_axi_rdy;
    sel_val_s  = i_n_axi_val[cur_s];
    accept_s   = active_s && out_free_s && sel_val_s;
    rdy_s         = '0;
    rdy_s[cur_s]  = active_s && out_free_s && i_rst;
  end

  // Beat mux from the served lane, with the source index stamped into ctl.
  always_comb begin
    sel_sop_s = i_n_axi_sop[cur_s];
    sel_eop_s = i_n_axi_eop[cur_s];
    sel_err_s = i_n_axi_err[cur_s];
    sel_dat_s = i_n_axi_dat[cur_s*DAT_W +: DAT_W];
    sel_ctl_s = i_n_axi_ctl[cur_s*CTL_BITS +: CTL_BITS];
    sel_mod_s = i_n_axi_mod[cur_s*MOD_BITS +: MOD_BITS];
    ctl_ovr_s = sel_ctl_s;
    ctl_ovr_s[OVR_WRT_BIT +: IDX_W] = cur_s;
  end

  // Next-state logic: lock onto the winner immediately, release once its eop is taken.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (any_val_s) begin
          state_d      = ST_LOCKED;
          grant_d      = win_s;
          last_grant_d = win_s;
        end else begin
          state_d      = ST_IDLE;
        end
      end
      ST_LOCKED: state_d = ST_LOCKED;
      default:   state_d = ST_IDLE;
    endcase
    state_d = (accept_s && sel_eop_s) ? ST_IDLE : state_d;
  end

  // Arbitration state; last_grant resets to the top lane so lane 0 wins first.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_IN - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Output pipeline register; advances only when the downstream slot is free.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_val_q <= 1'b0;
      o_sop_q <= 1'b0;
      o_eop_q <= 1'b0;
      o_err_q <= 1'b0;
      o_dat_q <= '0;
      o_ctl_q <= '0;
      o_mod_q <= '0;
    end else if (out_free_s) begin
      o_val_q <= accept_s;
      if (accept_s) begin
        o_sop_q <= sel_sop_s;
        o_eop_q <= sel_eop_s;
        o_err_q <= sel_err_s;
        o_dat_q <= sel_dat_s;
        o_ctl_q <= ctl_ovr_s;
        o_mod_q <= sel_mod_s;
      end
    end
  end

  assign i_n_axi_rdy = rdy_s;
  assign o_axi_val   = o_val_q;
  assign o_axi_sop   = o_sop_q;
  assign o_axi_eop   = o_eop_q;
  assign o_axi_err   = o_err_q;
  assign o_axi_dat   = o_dat_q;
  assign o_axi_ctl   = o_ctl_q;
  assign o_axi_mod   = o_mod_q;

endmodule

// File: doc/packet_rr_merge_n_to_1.md
Name: packet_rr_merge_n_to_1

Overview:
- Packet-aware round-robin merger: collects AXI-stream packets from NUM_IN worker lanes and emits them one whole packet at a time on a single output stream.
- Sits directly downstream of the workers fed by tree_packet_arb_1_to_n. It returns results to a single consumer.
- Writes the source lane index into a ctl field so the consumer can recover the origin of each packet.

Parameters:
- DAT_BYTS, 8, data bytes per beat on all interfaces.
- CTL_BITS, 8, ctl width on all interfaces; must be >= OVR_WRT_BIT + $clog2(NUM_IN).
- NUM_IN, 8, number of input lanes (>=2).
- OVR_WRT_BIT, 0, LSB of the ctl field overwritten with the source index.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  reset; asynchronous, active-low.
- i_n_axi  if_axi_stream slave [NUM_IN-1:0]  DAT_BYTS/CTL_BITS  input lanes.
- o_axi  if_axi_stream master  DAT_BYTS/CTL_BITS  merged output.

Behaviour:
- States: IDLE (no lane owned) and LOCKED (lane `grant` owns the output until its eop beat is accepted).
- Reset (i_rst=0, async):
  - state=IDLE, last_grant=NUM_IN-1, so lane 0 has first priority.
  - o_axi.val/sop/eop=0; dat/ctl/mod/err=0.
  - All i_n_axi[k].rdy=0.
- Arbitration in IDLE:
  - Pick the first lane k with i_n_axi[k].val=1, scanning from (last_grant+1) mod NUM_IN upward with wrap-around.
  - The winner becomes grant and is latched as last_grant; transition to LOCKED the same cycle the arbitration is made.
  - If no lane is valid, stay in IDLE.
  - The choice is combinational, but a beat is accepted on the cycle of the grant, so there is no idle bubble when a request is waiting.
- Lane selection: a lane is granted on its val alone; sop is not checked. A lane presenting val without sop is still treated as packet start, and it is the source's responsibility to present sop first.
- Data path: one output register stage (skid-free, full-throughput pipeline register).
  - i_n_axi[grant].rdy = LOCKED-or-winning && (!o_axi.val || o_axi.rdy).
  - Non-granted lanes: rdy=0 always.
  - Accepted beat is registered to o_axi one cycle later; latency is 1 cycle input-accept to output-valid.
  - dat/sop/eop/mod/err pass unchanged.
  - ctl is copied, except bits [OVR_WRT_BIT +: $clog2(NUM_IN)], which are replaced by grant.
- Backpressure: while o_axi.val=1 and o_axi.rdy=0, every o_axi field holds stable and no input beat is accepted.
- Packet end: when the granted lane's eop beat is accepted, return to IDLE.
  - Arbitration for the next packet may happen the following cycle.
  - Back-to-back packets from different lanes can therefore stream with at most one bubble between packets.
  - Throughput within a packet is 1 beat/cycle.
- Single-beat packet (sop=eop=1): accepted in one cycle, state returns to IDLE.
- Simultaneous requests: exactly one lane is granted; the others wait with rdy=0, and no beats are lost or interleaved.
- Fairness: with all lanes continuously requesting, the order is 0,1,...,NUM_IN-1,0,... regardless of packet length.
- Reset mid-packet: output valid drops immediately, the partial packet is discarded, state returns to IDLE, and priority restarts at lane 0.

Test Plan:
- Single lane: lane 3 sends a 4-beat packet with dat 0x11..0x44 and ctl=0 -> o_axi emits the 4 beats in order, sop on beat 1, eop on beat 4, ctl=3 on every beat, first output beat 1 cycle after acceptance.
- All 8 lanes valid simultaneously, each with a 2-beat packet -> output order is lanes 0..7, no interleaving, ctl matches source on every beat.
- Fairness: lanes 1 and 5 each send 10 packets continuously (lengths 1 and 6) -> packet sources alternate 1,5,1,5...
- Backpressure: random o_axi.rdy at 50% during 1000 random packets (1–8 beats) on random lanes -> output stable while stalled, data and source ctl match a per-lane scoreboard, no drops or duplicates.
- OVR_WRT_BIT=4, CTL_BITS=8, input ctl=0xFF from lane 2 -> output ctl=0xAF.
- Assert i_rst low during beat 2 of a 5-beat packet from lane 6, then release; lane 0 and lane 6 both valid -> o_axi.val=0 during reset, lane 0 granted first after release.
